// File: rtl/camera_pattern_pkg.sv
// camera_pattern_pkg
//   Shared definitions for the synthetic camera source: FSM state encoding,
//   pattern-mode constants and a small elaboration-time helper.
package camera_pattern_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VPRE   = 3'd2,
    ACTIVE = 3'd3,
    HSYNC  = 3'd4,
    HBLANK = 3'd5,
    VPOST  = 3'd6
  } camState_t;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_BAR   = 2'd3;

  // Used to size the shared cycle counter from the longest timed state.
  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/camera_pattern_pixel.sv
// camera_pattern_pixel
//   Combinational pixel generator: maps the current pixel coordinate and the
//   frame's latched mode settings to a pixel value.
// Ports
//   x           in   XW           pixel column (0..H_ACTIVE-1 when used)
//   y           in   YW           line number
//   mode        in   2            pattern mode (MODE_CONST/RAMP/CHECK/BAR)
//   constValue  in   PIXEL_WIDTH  value for MODE_CONST
//   barPos      in   XW           left edge of the moving bar
//   pixel       out  PIXEL_WIDTH  resulting pixel value
module camera_pattern_pixel
  import camera_pattern_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int H_ACTIVE    = 640,
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int TILE_LOG2   = 3,
  parameter int BAR_WIDTH   = 32
) (
  input  logic [XW-1:0]          x,
  input  logic [YW-1:0]          y,
  input  logic [1:0]             mode,
  input  logic [PIXEL_WIDTH-1:0] constValue,
  input  logic [XW-1:0]          barPos,
  output logic [PIXEL_WIDTH-1:0] pixel
);

  logic [31:0] xWide;
  logic [31:0] yWide;
  logic [31:0] barDist;
  logic        tileOdd;

  always_comb begin
    xWide = 32'(x);
    yWide = 32'(y);
    // Tile parity: low bit of (x>>T) xor low bit of (y>>T).
    tileOdd = (((xWide >> TILE_LOG2) & 32'd1) != ((yWide >> TILE_LOG2) & 32'd1));
    // Distance right of the bar's left edge, modulo the line width, so the
    // bar wraps across the right edge back to column 0.
    if (xWide >= 32'(barPos)) begin
      barDist = xWide - 32'(barPos);
    end else begin
      barDist = xWide + 32'(H_ACTIVE) - 32'(barPos);
    end
    pixel = '0;
    case (mode)
      MODE_CONST: pixel = constValue;
      MODE_RAMP:  pixel = xWide[PIXEL_WIDTH-1:0];
      MODE_CHECK: pixel = tileOdd ? '1 : '0;
      MODE_BAR:   pixel = (barDist < 32'(BAR_WIDTH)) ? '1 : '0;
      default:    pixel = '0;
    endcase
  end

endmodule

// File: rtl/camera_pattern_gen.sv
// camera_pattern_gen
//   Synthetic camera source producing hsync/vsync/validCamera/camData frames
//   with camera-interface timing, for self-test of the video pipeline.
//   validCamera is a pure qualifier with no backpressure: camData carries a
//   pixel exactly in the cycles validCamera is high and is 0 otherwise.
//   All outputs are registered.
// Ports
//   clock        in   1            system clock
//   reset        in   1            synchronous, active-high
//   enable       in   1            run frames continuously while high
//   mode         in   2            0 const, 1 h-ramp, 2 checkerboard, 3 moving bar
//   constValue   in   PIXEL_WIDTH  pixel value for mode 0
//   hsync        out  1            1-cycle pulse after the last pixel of each line
//   vsync        out  1            1-cycle pulse at frame start
//   validCamera  out  1            camData valid this cycle
//   camData      out  PIXEL_WIDTH  pixel value, 0 when not valid
//   frameDone    out  1            1-cycle pulse on the last cycle of V_POST
//   frameCount   out  16           completed frames, wrapping
//   busy         out  1            high from the VSYNC cycle to the end of V_POST
//   debugState   out  3            current FSM state
// Assumes V_PRE, H_BLANK, V_POST, PIXEL_PERIOD >= 1 and BAR_STEP < H_ACTIVE.
module camera_pattern_gen
  import camera_pattern_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 8,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PIXEL_PERIOD = 2,
  parameter int H_BLANK      = 20,
  parameter int V_PRE        = 50,
  parameter int V_POST       = 20,
  parameter int TILE_LOG2    = 3,
  parameter int BAR_WIDTH    = 32,
  parameter int BAR_STEP     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [PIXEL_WIDTH-1:0] constValue,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   validCamera,
  output logic [PIXEL_WIDTH-1:0] camData,
  output logic                   frameDone,
  output logic [15:0]            frameCount,
  output logic                   busy,
  output camState_t              debugState
);

  localparam int XW         = $clog2(H_ACTIVE + 1);
  localparam int YW         = $clog2(V_ACTIVE + 1);
  localparam int PW         = $clog2(PIXEL_PERIOD + 1);
  localparam int ACT_CYCLES = H_ACTIVE * PIXEL_PERIOD;
  localparam int CW         = $clog2(maxOf(maxOf(ACT_CYCLES, V_PRE),
                                           maxOf(H_BLANK, V_POST)) + 1);

  localparam logic [CW-1:0] ACT_LAST    = CW'(ACT_CYCLES - 1);
  localparam logic [CW-1:0] VPRE_LAST   = CW'(V_PRE - 1);
  localparam logic [CW-1:0] HBLANK_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VPOST_LAST  = CW'(V_POST - 1);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(PIXEL_PERIOD - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(V_ACTIVE - 1);
  localparam logic [XW:0]   X_SPAN      = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0]   STEP_X      = (XW+1)'(BAR_STEP);

  camState_t              state;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cntInc;
  logic [PW-1:0]          phase;
  logic [XW-1:0]          pixX;
  logic [YW-1:0]          lineY;
  logic                   lastLine;
  logic [XW-1:0]          barPos;
  logic [XW:0]            barSum;
  logic [XW-1:0]          barNext;
  logic [1:0]             modeReg;
  logic [PIXEL_WIDTH-1:0] constReg;
  logic [PIXEL_WIDTH-1:0] pixVal;
  logic                   finishNext;

  camera_pattern_pixel #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .H_ACTIVE    (H_ACTIVE),
    .XW          (XW),
    .YW          (YW),
    .TILE_LOG2   (TILE_LOG2),
    .BAR_WIDTH   (BAR_WIDTH)
  ) u_pixel (
    .x          (pixX),
    .y          (lineY),
    .mode       (modeReg),
    .constValue (constReg),
    .barPos     (barPos),
    .pixel      (pixVal)
  );

  assign cntInc     = cnt + CW'(1);
  assign debugState = state;

  always_comb begin
    barSum  = {1'b0, barPos} + STEP_X;
    barNext = barPos;
    if (barSum >= X_SPAN) begin
      barNext = XW'(barSum - X_SPAN);
    end else begin
      barNext = barSum[XW-1:0];
    end
  end

  // True when the next cycle is the last V_POST cycle, so frameDone (a
  // registered output) lands on that cycle. Covers V_POST == 1, where the
  // first VPOST cycle is also the last.
  always_comb begin
    finishNext = 1'b0;
    if (state == HBLANK && cnt == HBLANK_LAST && lastLine && V_POST == 1) begin
      finishNext = 1'b1;
    end
    if (state == VPOST && cnt != VPOST_LAST && cntInc == VPOST_LAST) begin
      finishNext = 1'b1;
    end
  end

  // Outputs are assigned on the edge that enters the cycle they describe.
  // pixX/lineY always point at the next pixel to emit, so pixVal is ready
  // on the edge that raises validCamera.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      phase       <= '0;
      pixX        <= '0;
      lineY       <= '0;
      lastLine    <= 1'b0;
      barPos      <= '0;
      modeReg     <= '0;
      constReg    <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      validCamera <= 1'b0;
      camData     <= '0;
      frameDone   <= 1'b0;
      frameCount  <= '0;
      busy        <= 1'b0;
    end else begin
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      validCamera <= 1'b0;
      camData     <= '0;
      frameDone   <= 1'b0;

      if (finishNext) begin
        frameDone  <= 1'b1;
        frameCount <= frameCount + 16'd1;
        barPos     <= barNext;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state <= VSYNC;
            vsync <= 1'b1;
            busy  <= 1'b1;
          end
        end
        VSYNC: begin
          modeReg  <= mode;
          constReg <= constValue;
          pixX     <= '0;
          lineY    <= '0;
          cnt      <= '0;
          state    <= VPRE;
        end
        VPRE: begin
          if (cnt == VPRE_LAST) begin
            state       <= ACTIVE;
            cnt         <= '0;
            phase       <= '0;
            validCamera <= 1'b1;
            camData     <= pixVal;
            pixX        <= pixX + XW'(1);
          end else begin
            cnt <= cntInc;
          end
        end
        ACTIVE: begin
          if (cnt == ACT_LAST) begin
            state <= HSYNC;
            hsync <= 1'b1;
          end else begin
            cnt <= cntInc;
            if (phase == PHASE_LAST) begin
              phase       <= '0;
              validCamera <= 1'b1;
              camData     <= pixVal;
              pixX        <= pixX + XW'(1);
            end else begin
              phase <= phase + PW'(1);
            end
          end
        end
        HSYNC: begin
          state    <= HBLANK;
          cnt      <= '0;
          pixX     <= '0;
          lastLine <= (lineY == Y_LAST);
          if (lineY != Y_LAST) begin
            lineY <= lineY + YW'(1);
          end
        end
        HBLANK: begin
          if (cnt == HBLANK_LAST) begin
            cnt <= '0;
            if (lastLine) begin
              state <= VPOST;
            end else begin
              state       <= ACTIVE;
              phase       <= '0;
              validCamera <= 1'b1;
              camData     <= pixVal;
              pixX        <= pixX + XW'(1);
            end
          end else begin
            cnt <= cntInc;
          end
        end
        VPOST: begin
          if (cnt == VPOST_LAST) begin
            if (enable) begin
              state <= VSYNC;
              vsync <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cntInc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_pattern_gen.sv
// tb_camera_pattern_gen
//   Directed sequence with randomized pixel settings. Expected per-cycle
//   outputs come from a frame-timing model computed with plain arithmetic
//   from the frame geometry and the pattern formulas.
module tb_camera_pattern_gen;
  import camera_pattern_pkg::*;

  localparam int PWID = 8;
  localparam int HA   = 8;
  localparam int VA   = 4;
  localparam int PP   = 2;
  localparam int HB   = 3;
  localparam int VPR  = 5;
  localparam int VPO  = 2;
  localparam int TL   = 1;
  localparam int BW   = 3;
  localparam int BS   = 2;
  localparam int LINE_CYC  = HA * PP + 1 + HB;
  localparam int FRAME_CYC = 1 + VPR + VA * LINE_CYC + VPO;

  // ---------------- clock / reset ----------------
  logic            clock_tb = 1'b0;
  logic            reset;
  logic            enable;
  logic [1:0]      mode;
  logic [PWID-1:0] constValue;
  logic            hsync;
  logic            vsync;
  logic            validCamera;
  logic [PWID-1:0] camData;
  logic            frameDone;
  logic [15:0]     frameCount;
  logic            busy;
  camState_t       debugState;

  always #5 clock_tb = ~clock_tb;

  camera_pattern_gen #(
    .PIXEL_WIDTH  (PWID),
    .H_ACTIVE     (HA),
    .V_ACTIVE     (VA),
    .PIXEL_PERIOD (PP),
    .H_BLANK      (HB),
    .V_PRE        (VPR),
    .V_POST       (VPO),
    .TILE_LOG2    (TL),
    .BAR_WIDTH    (BW),
    .BAR_STEP     (BS)
  ) dut (
    .clock       (clock_tb),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .constValue  (constValue),
    .hsync       (hsync),
    .vsync       (vsync),
    .validCamera (validCamera),
    .camData     (camData),
    .frameDone   (frameDone),
    .frameCount  (frameCount),
    .busy        (busy),
    .debugState  (debugState)
  );

  // ---------------- scoreboard ----------------
  int nCompared   = 0;
  int nMismatched = 0;
  int modelBar    = 0;
  int modelFrames = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    assert (got === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] refPixel(int md, int cv, int x, int y, int bar);
    int tw;
    tw = 1 << TL;
    case (md)
      0: return 8'(cv);
      1: return 8'(x % 256);
      2: return (((x / tw) + (y / tw)) % 2 == 1) ? 8'hFF : 8'h00;
      default: return ((((x - bar) % HA) + HA) % HA < BW) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Packed as {frameCount, busy, frameDone, vsync, hsync, validCamera, camData}.
  function automatic logic [28:0] refCycle(int t, int md, int cv, int bar, int fcBase);
    logic       vs, hs, vl, fd;
    logic [7:0] d;
    int         fc, lt, line, off;
    vs = 1'b0; hs = 1'b0; vl = 1'b0; fd = 1'b0; d = 8'h00; fc = fcBase;
    if (t == 0) begin
      vs = 1'b1;
    end else if (t >= 1 + VPR && t < 1 + VPR + VA * LINE_CYC) begin
      lt   = t - 1 - VPR;
      line = lt / LINE_CYC;
      off  = lt % LINE_CYC;
      if (off < HA * PP) begin
        if (off % PP == 0) begin
          vl = 1'b1;
          d  = refPixel(md, cv, off / PP, line, bar);
        end
      end else if (off == HA * PP) begin
        hs = 1'b1;
      end
    end
    if (t == FRAME_CYC - 1) begin
      fd = 1'b1;
      fc = (fcBase + 1) % 65536;
    end
    return {16'(fc), 1'b1, fd, vs, hs, vl, d};
  endfunction

  function automatic logic [28:0] obs();
    return {frameCount, busy, frameDone, vsync, hsync, validCamera, camData};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic waitVsync(input string tag);
    int n;
    n = 0;
    while (vsync !== 1'b1 && n < 300) begin
      @(posedge clock_tb); #1;
      n++;
    end
    check(tag, 32'(vsync), 32'd1);
  endtask

  // Called on the VSYNC cycle; checks every cycle of the frame and applies
  // the requested mid-frame stimulus after checking cycle t.
  task automatic runFrame(input int md, input int cv, input int changeAt,
                          input int newMode, input int newConst,
                          input int dropAt, input int resetAt, output bit aborted);
    aborted = 1'b0;
    for (int t = 0; t < FRAME_CYC; t++) begin
      check($sformatf("f%0d_m%0d_t%0d", modelFrames, md, t),
            32'(obs()), 32'(refCycle(t, md, cv, modelBar, modelFrames)));
      if (t == changeAt) begin
        mode       = 2'(newMode);
        constValue = 8'(newConst);
      end
      if (t == dropAt) enable = 1'b0;
      if (t == resetAt) begin
        reset   = 1'b1;
        enable  = 1'b0;
        aborted = 1'b1;
        break;
      end
      @(posedge clock_tb); #1;
    end
    if (aborted) begin
      @(posedge clock_tb); #1;
    end else begin
      modelBar = (modelBar + BS) % HA;
      modelFrames++;
    end
  endtask

  // ---------------- directed sequence ----------------
  bit ab;
  int curMode, curConst, nxtMode, nxtConst, activity;

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'd0; constValue = 8'h00;
    repeat (3) @(posedge clock_tb);
    #1;
    check("reset_outputs", 32'(obs()), 32'd0);
    check("reset_state", 32'(debugState), 32'(IDLE));
    reset = 1'b0;
    @(posedge clock_tb); #1;
    check("idle_disabled", 32'(obs()), 32'd0);

    // Constant, ramp, checkerboard, then two random-mode frames back to back.
    mode = 2'd0; constValue = 8'h01; enable = 1'b1;
    waitVsync("first_vsync");
    curConst = $urandom_range(255);
    runFrame(0, 1, FRAME_CYC - 1, 1, curConst, -1, -1, ab);
    runFrame(1, curConst, FRAME_CYC - 1, 2, curConst, -1, -1, ab);
    curMode = $urandom_range(3); curConst = $urandom_range(255);
    runFrame(2, curConst, FRAME_CYC - 1, curMode, curConst, -1, -1, ab);
    nxtMode = $urandom_range(3); nxtConst = $urandom_range(255);
    runFrame(curMode, curConst, FRAME_CYC - 1, nxtMode, nxtConst, -1, -1, ab);
    // Reset in the middle of a frame aborts it cleanly.
    runFrame(nxtMode, nxtConst, -1, 0, 0, -1, 30, ab);
    check("abort_taken", 32'(ab), 32'd1);
    check("midreset_outputs", 32'(obs()), 32'd0);
    check("midreset_state", 32'(debugState), 32'(IDLE));
    modelBar = 0; modelFrames = 0;
    reset = 1'b0;

    // Moving bar over five frames; the last one sees a mode change and an
    // enable drop mid-frame and must still finish with the bar pattern.
    curConst = $urandom_range(255);
    mode = MODE_BAR; constValue = 8'(curConst); enable = 1'b1;
    waitVsync("vsync_after_reset");
    for (int f = 0; f < 4; f++) runFrame(3, curConst, -1, 0, 0, -1, -1, ab);
    nxtConst = $urandom_range(255);
    runFrame(3, curConst, 20, 0, nxtConst, 40, -1, ab);
    check("frameCount_5", 32'(frameCount), 32'd5);
    check("stopped_busy", 32'(busy), 32'd0);
    check("stopped_state", 32'(debugState), 32'(IDLE));
    activity = 0;
    for (int i = 0; i < 150; i++) begin
      if (obs() !== {16'd5, 13'd0}) activity++;
      @(posedge clock_tb); #1;
    end
    check("quiet_after_stop", 32'(activity), 32'd0);

    // Re-enable: clean frame using the mode/const changed mid-frame above.
    enable = 1'b1;
    waitVsync("vsync_reenable");
    runFrame(0, nxtConst, -1, 0, 0, FRAME_CYC - 1, -1, ab);
    check("final_state", 32'(debugState), 32'(IDLE));
    check("final_frameCount", 32'(frameCount), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
